// File: rtl/menu_selector.sv
// Menu selection controller: synchronises and debounces three buttons and
// moves a selection marker whose row is updated only at frame boundaries.
module menu_selector #(
  parameter int         OPTIONS  = 3,
  parameter logic [9:0] BASE_X   = 10'd200,
  parameter logic [9:0] BASE_Y   = 10'd240,
  parameter logic [9:0] STEP_Y   = 10'd40,
  parameter int         DEBOUNCE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_enter,
  output logic [9:0] posx,
  output logic [9:0] posy,
  output logic [1:0] option,
  output logic       select
);

  localparam int              CW        = $clog2(DEBOUNCE);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(DEBOUNCE - 1);
  localparam logic [1:0]      OPT_LAST  = 2'(OPTIONS - 1);
  localparam int              BTN_UP    = 0;
  localparam int              BTN_DOWN  = 1;
  localparam int              BTN_ENTER = 2;

  typedef enum logic [1:0] {
    IDLE,
    NAVIGATE,
    CONFIRMED
  } state_e;

  logic [2:0]         raw;
  logic [2:0]         sync1_q, sync2_q;
  logic [2:0]         stable_q, stable_d;
  logic [2:0]         evt_q, evt_d;
  logic [2:0][CW-1:0] cnt_q, cnt_d;

  state_e             state_q, state_d;
  logic [1:0]         option_q, option_d;
  logic               select_q, select_d;
  logic [9:0]         posy_q, posy_d;

  assign raw = {btn_enter, btn_down, btn_up};

  // Debounce: stable only follows the synced level after DEBOUNCE
  // consecutive mismatching samples; a press event is a stable 0->1 step.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    stable_d = stable_q;
    cnt_d    = cnt_q;
    evt_d    = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
      evt_d[i] = stable_d[i] & ~stable_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    option_d = option_q;
    select_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = NAVIGATE;
          option_d = '0;
        end
        NAVIGATE: begin
          if (evt_q[BTN_ENTER]) begin
            select_d = 1'b1;
            state_d  = CONFIRMED;
          end else if (evt_q[BTN_UP] && !evt_q[BTN_DOWN]) begin
            option_d = (option_q == 2'd0) ? OPT_LAST : option_q - 2'd1;
          end else if (evt_q[BTN_DOWN] && !evt_q[BTN_UP]) begin
            option_d = (option_q == OPT_LAST) ? 2'd0 : option_q + 2'd1;
          end
        end
        CONFIRMED: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Marker row is a shadow register so it never changes mid-frame.
  always_comb begin
    posy_d = posy_q;
    if (frame_tick) posy_d = BASE_Y + 10'(option_q) * STEP_Y;
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      evt_q    <= '0;
      state_q  <= IDLE;
      option_q <= '0;
      select_q <= 1'b0;
      posy_q   <= BASE_Y;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
      state_q  <= state_d;
      option_q <= option_d;
      select_q <= select_d;
      posy_q   <= posy_d;
    end
  end

  assign posx   = BASE_X;
  assign posy   = posy_q;
  assign option = option_q;
  assign select = select_q;

endmodule

// File: tb/tb_menu_selector.sv
// Self-checking bench for menu_selector: a behavioural model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_menu_selector;

  localparam int D      = 4;
  localparam int OPTS   = 3;
  localparam int BASE_X = 200;
  localparam int BASE_Y = 240;
  localparam int STEP_Y = 40;
  localparam int HL     = D + 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_enter = 1'b0;
  logic [9:0] posx, posy;
  logic [1:0] option;
  logic       select;

  menu_selector #(
    .OPTIONS (OPTS),
    .BASE_X  (10'd200),
    .BASE_Y  (10'd240),
    .STEP_Y  (10'd40),
    .DEBOUNCE(D)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .frame_tick(frame_tick),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_enter (btn_enter),
    .posx      (posx),
    .posy      (posy),
    .option    (option),
    .select    (select)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int sel_count = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Behavioural model. Button k = 0 up, 1 down, 2 enter.
  // hist[k][j] is the raw level sampled j edges ago; the debounced level flips
  // when the D samples that have reached the synchroniser output all disagree.
  bit hist [3][HL];
  bit m_stable [3];
  bit m_evt [3];
  int m_opt, m_posy;
  bit m_sel, m_in_menu, m_locked;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < HL; j++) hist[k][j] = 1'b0;
      m_stable[k] = 1'b0;
      m_evt[k]    = 1'b0;
    end
    m_opt = 0; m_posy = BASE_Y; m_sel = 1'b0;
    m_in_menu = 1'b0; m_locked = 1'b0;
  endtask

  task automatic model_step();
    bit raw [3];
    bit flip;
    raw[0] = btn_up; raw[1] = btn_down; raw[2] = btn_enter;
    if (frame_tick) m_posy = (BASE_Y + m_opt * STEP_Y) % 1024;
    m_sel = 1'b0;
    if (!enable) begin
      m_in_menu = 1'b0;
      m_locked  = 1'b0;
    end else if (!m_in_menu) begin
      m_in_menu = 1'b1;
      m_locked  = 1'b0;
      m_opt     = 0;
    end else if (!m_locked) begin
      if (m_evt[2]) begin
        m_sel = 1'b1;
        m_locked = 1'b1;
      end else if (m_evt[0] && !m_evt[1]) m_opt = (m_opt + OPTS - 1) % OPTS;
      else if (m_evt[1] && !m_evt[0]) m_opt = (m_opt + 1) % OPTS;
    end
    for (int k = 0; k < 3; k++) begin
      for (int j = HL - 1; j > 0; j--) hist[k][j] = hist[k][j-1];
      hist[k][0] = raw[k];
      flip = 1'b1;
      for (int j = 2; j <= D + 1; j++) if (hist[k][j] == m_stable[k]) flip = 1'b0;
      m_evt[k] = flip && !m_stable[k];
      if (flip) m_stable[k] = !m_stable[k];
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  initial begin
    #2;
    forever begin
      @(negedge clock);
      check("posx", int'(posx), BASE_X);
      check("posy", int'(posy), m_posy);
      check("option", int'(option), m_opt);
      check("select", int'(select), int'(m_sel));
      if (select) sel_count++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #2;
  endtask

  task automatic set_btn(input int k, input bit v);
    case (k)
      0: btn_up = v;
      1: btn_down = v;
      default: btn_enter = v;
    endcase
  endtask

  task automatic press(input int k);
    set_btn(k, 1'b1);
    tick(D + 4);
    set_btn(k, 1'b0);
    tick(D + 4);
  endtask

  task automatic frame_pulse();
    frame_tick = 1'b1;
    tick(1);
    frame_tick = 1'b0;
    tick(1);
  endtask

  int base;

  initial begin
    #1 reset = 1'b1;
    #1;
    check("rst_posx", int'(posx), 200);
    check("rst_posy", int'(posy), 240);
    check("rst_option", int'(option), 0);
    check("rst_select", int'(select), 0);
    @(negedge clock); #2;
    enable = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);

    // Held down press: option moves exactly D+3 edges after the raw edge
    btn_down = 1'b1;
    tick(D + 2);
    check("down_not_early", int'(option), 0);
    tick(1);
    check("down_latency", int'(option), 1);
    check("posy_holds", int'(posy), 240);
    frame_pulse();
    check("posy_at_tick", int'(posy), 280);
    btn_down = 1'b0;
    tick(D + 4);

    // Disable holds option, re-enable forces 0
    enable = 1'b0;
    tick(2);
    check("idle_holds_opt", int'(option), 1);
    enable = 1'b1;
    tick(2);
    check("reenable_zero", int'(option), 0);

    press(0);
    check("up_wrap", int'(option), 2);
    frame_pulse();
    check("posy_opt2", int'(posy), 320);
    press(1);
    check("down_wrap", int'(option), 0);
    press(1);
    check("down_inc", int'(option), 1);
    frame_pulse();
    check("posy_opt1", int'(posy), 280);

    // Option change on the same edge as frame_tick shows at the next tick
    btn_down = 1'b1;
    tick(D + 2);
    frame_tick = 1'b1;
    tick(1);
    frame_tick = 1'b0;
    check("coincide_opt", int'(option), 2);
    check("coincide_posy_old", int'(posy), 280);
    frame_pulse();
    check("coincide_posy_next", int'(posy), 320);
    btn_down = 1'b0;
    tick(D + 4);

    // Bouncing input is rejected, then a 6-cycle hold gives one step
    for (int i = 0; i < 5; i++) begin
      btn_down = 1'b1; tick(2);
      btn_down = 1'b0; tick(2);
    end
    check("bounce_rejected", int'(option), 2);
    btn_down = 1'b1;
    tick(6);
    btn_down = 1'b0;
    tick(10);
    check("hold_one_step", int'(option), 0);

    // Up and down together cancel
    btn_up = 1'b1; btn_down = 1'b1;
    tick(D + 4);
    btn_up = 1'b0; btn_down = 1'b0;
    tick(D + 4);
    check("up_down_cancel", int'(option), 0);

    // Enter wins over down; confirmed state ignores everything
    base = sel_count;
    btn_enter = 1'b1; btn_down = 1'b1;
    tick(D + 4);
    btn_enter = 1'b0; btn_down = 1'b0;
    tick(D + 4);
    check("select_once", sel_count - base, 1);
    check("enter_priority", int'(option), 0);
    press(1);
    press(0);
    press(2);
    check("confirmed_ignores", int'(option), 0);
    check("no_second_select", sel_count - base, 1);
    enable = 1'b0; tick(2);
    enable = 1'b1; tick(2);
    press(1);
    check("renavigate", int'(option), 1);

    // Reset during an enter debounce aborts it
    base = sel_count;
    btn_enter = 1'b1;
    tick(2);
    reset = 1'b1;
    #1;
    check("mid_rst_posy", int'(posy), 240);
    check("mid_rst_option", int'(option), 0);
    check("mid_rst_select", int'(select), 0);
    @(negedge clock); #2;
    btn_enter = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(12);
    check("abort_no_select", sel_count - base, 0);
    check("abort_option", int'(option), 0);
    check("abort_posy", int'(posy), 240);
    check("abort_posx", int'(posx), 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
